fsmc_slave_arbiter: RTL

Sits between the FSMC bus interface and the register peripherals behind it, replacing direct wiring of one chip-select bit to a single register block. It decodes the interface's one-hot chip-select and read/write state into per-slave strobes and waits for a slave acknowledge. It returns read data from the selected slave, and bounds every access with a timeout so a missing slave cannot hang the bus. One transaction is issued per chip-select assertion.

---
 rtl/fsmc_slave_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fsmc_slave_arbiter.sv
// Routes one-hot FSMC chip-select accesses to per-slave strobes, waits for ack, bounds with timeout.
// Build macro FSMC_ARB_STATS_EN adds saturating acc_cnt/to_cnt statistics outputs.
module fsmc_slave_arbiter #(
  parameter int unsigned       NUM_SLAVES   = 4,
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       TIMEOUT_CYC  = 64,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_SLAVES-1:0]        cs,
  input  logic                         state,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [DATA_W-1:0]            rd_data,
  output logic [NUM_SLAVES-1:0]        slv_sel,
  output logic                         slv_rd,
  output logic                         slv_wr,
  output logic [DATA_W-1:0]            slv_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLAVES-1:0]        slv_ack,
  output logic                         busy,
  input  logic                         err_clr,
  output logic                         err_timeout,
  output logic                         err_multi
`ifdef FSMC_ARB_STATS_EN
  ,
  output logic [15:0]                  acc_cnt,
  output logic [15:0]                  to_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam int unsigned     CntW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [1:0]            r_state, w_state;
  logic [CntW-1:0]       r_cnt, w_cnt;
  logic [NUM_SLAVES-1:0] r_sel, w_sel;
  logic                  r_rd, w_rd, r_wr, w_wr;
  logic [DATA_W-1:0]     r_wdata, w_wdata, r_rdata, w_rdata, w_slice;
  logic                  r_err_to, w_err_to, r_err_multi, w_err_multi;
  logic                  w_ack, w_timeout, w_to_set;

  always_comb begin
    w_slice = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel[i]) w_slice = slv_rdata[DATA_W*i +: DATA_W];
    end
  end

  // Only the latched slave's ack counts; stray acks are ignored.
  assign w_ack     = |(slv_ack & r_sel);
  assign w_timeout = (r_cnt == CntLast);

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_sel       = r_sel;
    w_rd        = r_rd;
    w_wr        = r_wr;
    w_wdata     = r_wdata;
    w_rdata     = r_rdata;
    w_to_set    = 1'b0;
    w_err_multi = r_err_multi & ~err_clr;
    case (r_state)
      IDLE: begin
        if ($onehot(cs)) begin
          w_state = REQ;
          w_cnt   = '0;
          w_sel   = cs;
          w_rd    = state;
          w_wr    = ~state;
          w_wdata = wr_data;
        end else if (cs != '0) begin
          w_state     = HOLD;
          w_err_multi = 1'b1;
        end
      end
      REQ: begin
        // Priority: ack, then host abort, then timeout.
        if (w_ack) begin
          if (r_rd) w_rdata = w_slice;
          w_state = HOLD;
        end else if (cs == '0) begin
          w_state = IDLE;
        end else if (w_timeout) begin
          if (r_rd) w_rdata = TIMEOUT_DATA;
          w_to_set = 1'b1;
          w_state  = HOLD;
        end else begin
          w_cnt = r_cnt + CntW'(1);
        end
        if (w_state != REQ) begin
          w_sel = '0;
          w_rd  = 1'b0;
          w_wr  = 1'b0;
        end
      end
      HOLD: begin
        if (cs == '0) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
    w_err_to = (r_err_to & ~err_clr) | w_to_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err_to    <= 1'b0;
      r_err_multi <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_sel       <= w_sel;
      r_rd        <= w_rd;
      r_wr        <= w_wr;
      r_wdata     <= w_wdata;
      r_rdata     <= w_rdata;
      r_err_to    <= w_err_to;
      r_err_multi <= w_err_multi;
    end
  end

  assign rd_data     = r_rdata;
  assign slv_sel     = r_sel;
  assign slv_rd      = r_rd;
  assign slv_wr      = r_wr;
  assign slv_wdata   = r_wdata;
  assign busy        = (r_state != IDLE);
  assign err_timeout = r_err_to;
  assign err_multi   = r_err_multi;

`ifdef FSMC_ARB_STATS_EN
  logic [15:0] r_acc_cnt, r_to_cnt;
  logic        w_acc_evt;

  assign w_acc_evt = (r_state == REQ) && w_ack;

  // A clear coinciding with an event leaves the counter at 1, mirroring set-wins on the flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      if (err_clr) r_acc_cnt <= {15'd0, w_acc_evt};
      else if (w_acc_evt && (r_acc_cnt != 16'hFFFF)) r_acc_cnt <= r_acc_cnt + 16'd1;
      if (err_clr) r_to_cnt <= {15'd0, w_to_set};
      else if (w_to_set && (r_to_cnt != 16'hFFFF)) r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  assign acc_cnt = r_acc_cnt;
  assign to_cnt  = r_to_cnt;
`endif

endmodule
